// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

  localparam int REG_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_word_t;

  // Every pipeline register loads this word when flushed or bubbled.
  localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 3
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic             id_rs1_used;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_wr_en;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_fo_en;
  logic             fo_ex_en;
  logic             if_id_flush;
  logic             id_fo_bubble;
  logic             hazard_stall;
  logic [1:0]       state_o;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wr_en,
           wb_valid, wb_rd, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_fo_en, fo_ex_en, if_id_flush, id_fo_bubble,
           hazard_stall, state_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wr_en,
           wb_valid, wb_rd, ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_fo_en, fo_ex_en, if_id_flush, id_fo_bubble,
           hazard_stall, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// rtl/pipeline_hazard_ctrl_scoreboard.sv - per-register outstanding-write counters
module hazard_scoreboard #(
  parameter int REG_W = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_issue,
  input  logic [REG_W-1:0] i_issue_rd,
  input  logic             i_retire,
  input  logic [REG_W-1:0] i_retire_rd,
  input  logic             i_squash,
  input  logic [REG_W-1:0] i_squash_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_pend_rs1,
  output logic             o_pend_rs2,
  output logic             o_sat_rd
);
  localparam int NREG  = 1 << REG_W;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt [NREG];

  // Increment and both decrements net together; the result clamps to [0, max].
  function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                              input logic dec_a, input logic dec_b);
    logic [SUM_W-1:0] up, dn, res;
    up = {2'b00, cnt} + SUM_W'(inc);
    dn = SUM_W'(dec_a) + SUM_W'(dec_b);
    if (up <= dn) res = '0;
    else          res = up - dn;
    if (res > CNT_MAX) res = CNT_MAX;
    return res[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        r_cnt[i] <= f_next(r_cnt[i],
                           i_issue  && (i_issue_rd  == REG_W'(i)),
                           i_retire && (i_retire_rd == REG_W'(i)),
                           i_squash && (i_squash_rd == REG_W'(i)));
    end
  end

  assign o_pend_rs1 = (r_cnt[i_rs1] != '0);
  assign o_pend_rs2 = (r_cnt[i_rs2] != '0);
  assign o_sat_rd   = &r_cnt[i_rd];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_flush_cnt;
  logic [REG_W-1:0] r_fo_rd;
  logic             r_fo_wr;

  logic w_pend_rs1, w_pend_rs2, w_sat_rd;
  logic w_mem_stall, w_act, w_hazard, w_branch, w_issue, w_squash;
  logic w_pc_en, w_if_id_en, w_id_fo_en, w_fo_ex_en, w_if_id_flush, w_id_fo_bubble, w_stall;

  hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_issue     (w_issue),
    .i_issue_rd  (bus.id_rd),
    .i_retire    (bus.wb_valid),
    .i_retire_rd (bus.wb_rd),
    .i_squash    (w_squash),
    .i_squash_rd (r_fo_rd),
    .i_rs1       (bus.id_rs1),
    .i_rs2       (bus.id_rs2),
    .i_rd        (bus.id_rd),
    .o_pend_rs1  (w_pend_rs1),
    .o_pend_rs2  (w_pend_rs2),
    .o_sat_rd    (w_sat_rd)
  );

  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
  // The cycle that releases MEM_WAIT behaves exactly like a RUN cycle.
  assign w_act    = (r_state == ST_RUN) | ((r_state == ST_MEM_WAIT) & ~w_mem_stall);
  assign w_hazard = w_act & bus.id_valid & ((bus.id_rs1_used & w_pend_rs1) |
                                            (bus.id_rs2_used & w_pend_rs2) |
                                            (bus.id_wr_en & w_sat_rd));
  assign w_branch = w_act & ~w_mem_stall & bus.ex_branch_taken;
  assign w_issue  = w_act & bus.id_valid & bus.id_wr_en & ~w_hazard & ~w_mem_stall &
                    ~bus.ex_branch_taken;
  assign w_squash = w_branch & r_fo_wr;

  always_comb begin
    {w_pc_en, w_if_id_en, w_id_fo_en, w_fo_ex_en} = 4'b0000;
    {w_if_id_flush, w_id_fo_bubble, w_stall}      = 3'b000;
    if (!rst_n) begin
      {w_if_id_flush, w_id_fo_bubble} = 2'b11;
    end else if (r_state == ST_FLUSH) begin
      {w_pc_en, w_if_id_en, w_id_fo_en, w_fo_ex_en} = 4'b1111;
      {w_if_id_flush, w_id_fo_bubble}               = 2'b11;
    end else if (w_act && !w_mem_stall) begin
      {w_pc_en, w_if_id_en, w_id_fo_en, w_fo_ex_en} = 4'b1111;
      if (w_branch) begin
        {w_if_id_flush, w_id_fo_bubble} = 2'b11;
      end else if (w_hazard) begin
        {w_pc_en, w_if_id_en}     = 2'b00;
        {w_id_fo_bubble, w_stall} = 2'b11;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_fo_rd     <= '0;
      r_fo_wr     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (w_mem_stall) begin
            r_state <= ST_MEM_WAIT;
          end else if (w_branch) begin
            r_flush_cnt <= FLUSH_LOAD;
            r_state     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 2'd1;
          if (r_flush_cnt <= 2'd1) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
      if (w_id_fo_en) begin
        r_fo_rd <= bus.id_rd;
        r_fo_wr <= w_issue & ~w_id_fo_bubble;
      end
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.id_fo_en     = w_id_fo_en;
  assign bus.fo_ex_en     = w_fo_ex_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_fo_bubble = w_id_fo_bubble;
  assign bus.hazard_stall = w_stall;
  assign bus.state_o      = r_state;

endmodule
